// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator with selectable test pattern
//
// Ports:
//   clk          pixel clock
//   rst          asynchronous reset, active-high
//   en           run enable; low forces counters to 0 and outputs to idle
//   pattern_sel  0 colour bars, 1 grey ramp, 2 checkerboard, 3 solid grey
//   data_out     {R,G,B} pixel, zero outside active video
//   hs_out       horizontal sync, active level HS_POL
//   vs_out       vertical sync, active level VS_POL
//   de_out       active-video enable
//   h_cnt_out    horizontal position of the output pixel
//   v_cnt_out    vertical position of the output pixel
//   frame_start  one-clock pulse on pixel h=0, v=0
module video_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    output logic [23:0] data_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic        de_out,
    output logic [11:0] h_cnt_out,
    output logic [11:0] v_cnt_out,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

    // Window bounds are 13 bits so an end bound of 4096 does not wrap to 0.
    localparam logic [12:0] H_ACT    = 13'(H_ACTIVE);
    localparam logic [12:0] V_ACT    = 13'(V_ACTIVE);
    localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] VS_START = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    // Colour bar boundaries; H_ACTIVE is a multiple of 8 so these are exact.
    localparam int          BAR_W = H_ACTIVE / 8;
    localparam logic [12:0] BAR1  = 13'(1 * BAR_W);
    localparam logic [12:0] BAR2  = 13'(2 * BAR_W);
    localparam logic [12:0] BAR3  = 13'(3 * BAR_W);
    localparam logic [12:0] BAR4  = 13'(4 * BAR_W);
    localparam logic [12:0] BAR5  = 13'(5 * BAR_W);
    localparam logic [12:0] BAR6  = 13'(6 * BAR_W);
    localparam logic [12:0] BAR7  = 13'(7 * BAR_W);

    logic [11:0] h;
    logic [11:0] v;
    logic [1:0]  pat;

    logic [11:0] h_nxt;
    logic [11:0] v_nxt;
    logic [12:0] hx;
    logic [12:0] vx;
    logic        active;
    logic        in_hs;
    logic        in_vs;
    logic [23:0] bar_rgb;
    logic [23:0] pix;

    always_comb begin
        h_nxt = h + 12'd1;
        v_nxt = v;
        if (h == H_LAST) begin
            h_nxt = 12'd0;
            v_nxt = (v == V_LAST) ? 12'd0 : v + 12'd1;
        end
    end

    always_comb begin
        hx     = {1'b0, h};
        vx     = {1'b0, v};
        active = (hx < H_ACT) && (vx < V_ACT);
        in_hs  = (hx >= HS_START) && (hx < HS_END);
        in_vs  = (vx >= VS_START) && (vx < VS_END);
    end

    always_comb begin
        bar_rgb = 24'h000000;
        if      (hx < BAR1) bar_rgb = 24'hFFFFFF;
        else if (hx < BAR2) bar_rgb = 24'hFFFF00;
        else if (hx < BAR3) bar_rgb = 24'h00FFFF;
        else if (hx < BAR4) bar_rgb = 24'h00FF00;
        else if (hx < BAR5) bar_rgb = 24'hFF00FF;
        else if (hx < BAR6) bar_rgb = 24'hFF0000;
        else if (hx < BAR7) bar_rgb = 24'h0000FF;
        else                bar_rgb = 24'h000000;
    end

    always_comb begin
        pix = 24'h000000;
        if (active) begin
            case (pat)
                2'd0:    pix = bar_rgb;
                2'd1:    pix = {h[7:0], h[7:0], h[7:0]};
                2'd2:    pix = (h[5] ^ v[5]) ? 24'hFFFFFF : 24'h000000;
                default: pix = 24'h808080;
            endcase
        end
    end

    // Outputs describe the counter value present before each edge, so they
    // trail the counters by one clock and stay mutually aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h           <= 12'd0;
            v           <= 12'd0;
            pat         <= 2'd0;
            data_out    <= 24'h000000;
            hs_out      <= ~HS_ON;
            vs_out      <= ~VS_ON;
            de_out      <= 1'b0;
            h_cnt_out   <= 12'd0;
            v_cnt_out   <= 12'd0;
            frame_start <= 1'b0;
        end else if (!en) begin
            // Counters parked at the frame origin; the pattern keeps tracking
            // pattern_sel so the frame that starts on en rising uses it.
            h           <= 12'd0;
            v           <= 12'd0;
            pat         <= pattern_sel;
            data_out    <= 24'h000000;
            hs_out      <= ~HS_ON;
            vs_out      <= ~VS_ON;
            de_out      <= 1'b0;
            h_cnt_out   <= 12'd0;
            v_cnt_out   <= 12'd0;
            frame_start <= 1'b0;
        end else begin
            h <= h_nxt;
            v <= v_nxt;
            if ((h_nxt == 12'd0) && (v_nxt == 12'd0)) begin
                pat <= pattern_sel;
            end
            data_out    <= pix;
            hs_out      <= in_hs ? HS_ON : ~HS_ON;
            vs_out      <= in_vs ? VS_ON : ~VS_ON;
            de_out      <= active;
            h_cnt_out   <= h;
            v_cnt_out   <= v;
            frame_start <= (h == 12'd0) && (v == 12'd0);
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - self-checking bench for video_timing_gen
module tb_video_timing_gen;

    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HSW = 3;
    localparam int HBP = 3;
    localparam int VA  = 4;
    localparam int VFP = 1;
    localparam int VSW = 2;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;

    // Idle vector: data 0, hs low (HS_POL=1), vs high (VS_POL=0), de 0, fs 0, h 0, v 0.
    localparam logic [51:0] RESET_VEC = {24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 12'd0};

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  pattern_sel;
    logic [23:0] data_out;
    logic        hs_out;
    logic        vs_out;
    logic        de_out;
    logic [11:0] h_cnt_out;
    logic [11:0] v_cnt_out;
    logic        frame_start;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1), .VS_POL(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .pattern_sel(pattern_sel),
        .data_out(data_out),
        .hs_out(hs_out),
        .vs_out(vs_out),
        .de_out(de_out),
        .h_cnt_out(h_cnt_out),
        .v_cnt_out(v_cnt_out),
        .frame_start(frame_start)
    );

    logic [51:0] dut_vec;
    assign dut_vec = {data_out, hs_out, vs_out, de_out, frame_start, h_cnt_out, v_cnt_out};

    int checks   = 0;
    int failures = 0;

    logic [51:0] sb_q[$];
    int          mh;
    int          mv;
    logic [1:0]  mpat;

    function automatic logic [51:0] pack(input logic [23:0] d, input logic hs, input logic vs,
                                         input logic de, input logic fs,
                                         input int h, input int v);
        return {d, hs, vs, de, fs, 12'(h), 12'(v)};
    endfunction

    function automatic logic [23:0] bar_colour(input int k);
        case (k)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [51:0] model_out(input int h, input int v, input logic [1:0] p);
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] d;
        logic [7:0]  g;
        de = (h < HA) && (v < VA);
        hs = (h >= HA + HFP) && (h < HA + HFP + HSW);
        vs = !((v >= VA + VFP) && (v < VA + VFP + VSW));
        g  = 8'(h % 256);
        d  = 24'h000000;
        if (de) begin
            case (p)
                2'd0: d = bar_colour(h / (HA / 8));
                2'd1: d = {g, g, g};
                2'd2: d = (((h / 32) % 2) != ((v / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
                default: d = 24'h808080;
            endcase
        end
        return pack(d, hs, vs, de, (h == 0) && (v == 0), h, v);
    endfunction

    task automatic cmp(input string name, input logic [51:0] act, input logic [51:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cmp_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, push the expected output, then compare on the falling edge.
    task automatic step(input logic e, input logic [1:0] p);
        en          = e;
        pattern_sel = p;
        if (!e) begin
            sb_q.push_back(RESET_VEC);
            mh   = 0;
            mv   = 0;
            mpat = p;
        end else begin
            sb_q.push_back(model_out(mh, mv, mpat));
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end
            if (mh == 0 && mv == 0) mpat = p;
        end
        @(posedge clk);
        @(negedge clk);
        if (sb_q.size() == 0) cmp_int("scoreboard_empty", 0, 1);
        else cmp("scoreboard", dut_vec, sb_q.pop_front());
    endtask

    typedef struct {
        string       name;
        logic        en;
        logic [1:0]  ps;
        int          n;
        logic [51:0] exp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int de_cnt, fs_cnt, fs_at, vs_cnt, vs_bad, hs_cnt, hs_bad, de_late, de_line0, wraps, wrap_bad;
        int ph, pv;

        tbl[0]  = '{"first_pixel",  1'b1, 2'd0, 1,  pack(24'hFFFFFF, 0, 1, 1, 1, 0, 0)};
        tbl[1]  = '{"bar1_h2",      1'b1, 2'd0, 2,  pack(24'hFFFF00, 0, 1, 1, 0, 2, 0)};
        tbl[2]  = '{"bar7_h15",     1'b1, 2'd0, 13, pack(24'h000000, 0, 1, 1, 0, 15, 0)};
        tbl[3]  = '{"hsync_h19",    1'b1, 2'd0, 4,  pack(24'h000000, 1, 1, 0, 0, 19, 0)};
        tbl[4]  = '{"line_wrap",    1'b1, 2'd0, 5,  pack(24'hFFFFFF, 0, 1, 1, 0, 0, 1)};
        tbl[5]  = '{"sel_midframe", 1'b1, 2'd1, 1,  pack(24'hFFFFFF, 0, 1, 1, 0, 1, 1)};
        tbl[6]  = '{"vsync_line5",  1'b1, 2'd1, 95, pack(24'h000000, 0, 0, 0, 0, 0, 5)};
        tbl[7]  = '{"ramp_frame0",  1'b1, 2'd1, 72, pack(24'h000000, 0, 1, 1, 1, 0, 0)};
        tbl[8]  = '{"ramp_h15",     1'b1, 2'd1, 15, pack(24'h0F0F0F, 0, 1, 1, 0, 15, 0)};
        tbl[9]  = '{"ramp_h7_v2",   1'b1, 2'd1, 40, pack(24'h070707, 0, 1, 1, 0, 7, 2)};
        tbl[10] = '{"en_drop",      1'b0, 2'd3, 1,  RESET_VEC};
        tbl[11] = '{"en_hold",      1'b0, 2'd3, 5,  RESET_VEC};
        tbl[12] = '{"en_rise",      1'b1, 2'd3, 1,  pack(24'h808080, 0, 1, 1, 1, 0, 0)};
        tbl[13] = '{"grey_h10",     1'b1, 2'd3, 10, pack(24'h808080, 0, 1, 1, 0, 10, 0)};

        rst         = 1'b1;
        en          = 1'b1;
        pattern_sel = 2'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp("reset_hold", dut_vec, RESET_VEC);
        end
        rst  = 1'b0;
        mh   = 0;
        mv   = 0;
        mpat = 2'd0;

        for (int i = 0; i < 14; i++) begin
            for (int j = 0; j < tbl[i].n; j++) step(tbl[i].en, tbl[i].ps);
            cmp(tbl[i].name, dut_vec, tbl[i].exp);
        end

        // Asynchronous reset pulse between edges at h_cnt_out=10.
        #2;
        rst = 1'b1;
        #1;
        cmp("async_reset", dut_vec, RESET_VEC);
        #1;
        rst  = 1'b0;
        mh   = 0;
        mv   = 0;
        mpat = 2'd0;
        step(1'b1, 2'd3);
        cmp("async_restart", dut_vec, pack(24'hFFFFFF, 0, 1, 1, 1, 0, 0));

        // One full frame from the restart origin to the next frame origin.
        de_cnt = 0; fs_cnt = 0; fs_at = -1; vs_cnt = 0; vs_bad = 0; hs_cnt = 0;
        hs_bad = 0; de_late = 0; de_line0 = 0; wraps = 0; wrap_bad = 0;
        for (int c = 1; c <= HT * VT; c++) begin
            ph = int'(h_cnt_out);
            pv = int'(v_cnt_out);
            step(1'b1, 2'd1);
            if (de_out) de_cnt++;
            if (de_out && v_cnt_out == 12'd0) de_line0++;
            if (de_out && v_cnt_out >= 12'd4) de_late++;
            if (frame_start) begin
                fs_cnt++;
                fs_at = c;
            end
            if (!vs_out) begin
                vs_cnt++;
                if (v_cnt_out < 12'd5 || v_cnt_out > 12'd6) vs_bad++;
            end
            if (hs_out) begin
                hs_cnt++;
                if (h_cnt_out < 12'd18 || h_cnt_out > 12'd20) hs_bad++;
            end
            if (h_cnt_out == 12'd0) begin
                wraps++;
                if (ph != HT - 1 || int'(v_cnt_out) != (pv + 1) % VT) wrap_bad++;
            end
        end
        cmp_int("de_per_frame", de_cnt, 64);
        cmp_int("de_per_line", de_line0, 16);
        cmp_int("de_blank_lines", de_late, 0);
        cmp_int("fs_count", fs_cnt, 1);
        cmp_int("fs_period", fs_at, 192);
        cmp_int("vs_low_cycles", vs_cnt, 48);
        cmp_int("vs_window", vs_bad, 0);
        cmp_int("hs_high_cycles", hs_cnt, 24);
        cmp_int("hs_window", hs_bad, 0);
        cmp_int("wrap_count", wraps, 8);
        cmp_int("wrap_v_step", wrap_bad, 0);

        // Frame after the restart latched pattern 1: ramp value at h=5.
        for (int j = 0; j < 5; j++) step(1'b1, 2'd1);
        cmp("ramp_after_restart", dut_vec, pack(24'h050505, 0, 1, 1, 0, 5, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
